// File: rtl/fpu_hazard_pkg.sv
// Shared constants for the FPU hazard controller: forwarding select codes,
// default iterative-unit latencies and the per-operand hazard result type.
package fpu_hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_LD = 2'd1;
  localparam logic [1:0] FWD_FP = 2'd2;

  localparam int DIV_LAT_DEF  = 16;
  localparam int SQRT_LAT_DEF = 16;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd;
  } op_hz_t;

endpackage

// File: rtl/fpu_stage_track.sv
// Destination tracker for the DEPTH-stage FPU pipe: e1 captures the ID
// destination every cycle; a bubble is simply a cleared write enable.
module fpu_stage_track
  import fpu_hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = 5
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic [AW-1:0]       i_fd,
  input  logic                i_we,
  output logic [DEPTH*AW-1:0] o_e_n,
  output logic [DEPTH-1:0]    o_e_w
);

  logic [DEPTH-1:0][AW-1:0] r_n;
  logic [DEPTH-1:0]         r_w;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_n <= '0;
      r_w <= '0;
    end else begin
      r_n[0] <= i_fd;
      r_w[0] <= i_we;
      for (int k = 1; k < DEPTH; k++) begin
        r_n[k] <= r_n[k-1];
        r_w[k] <= r_w[k-1];
      end
    end
  end

  assign o_e_n = r_n;
  assign o_e_w = r_w;

endmodule

// File: rtl/fpu_hazard_ctrl.sv
// FP hazard/scoreboard controller: ID stall and fs/ft forwarding selects over a
// DEPTH-stage FPU pipe plus one iterative div/sqrt unit. FPU_LOAD_FWD_EN enables MEM load forwarding.
module fpu_hazard_ctrl
  import fpu_hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int SQRT_LAT = SQRT_LAT_DEF,
  parameter int CW       = 5
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic [AW-1:0]       i_id_fs,
  input  logic [AW-1:0]       i_id_ft,
  input  logic                i_id_use_fs,
  input  logic                i_id_use_ft,
  input  logic                i_id_fop,
  input  logic                i_id_ldiv,
  input  logic                i_id_lsqrt,
  input  logic                i_id_wf,
  input  logic [AW-1:0]       i_id_fd,
  input  logic                i_ex_lwc1,
  input  logic [AW-1:0]       i_ex_ld_rt,
  input  logic                i_mem_lwc1,
  input  logic [AW-1:0]       i_mem_ld_rt,
  output logic                o_stall,
  output logic [1:0]          o_fwd_a,
  output logic [1:0]          o_fwd_b,
  output logic [DEPTH*AW-1:0] o_e_n,
  output logic [DEPTH-1:0]    o_e_w,
  output logic                o_lu_busy,
  output logic                o_lu_done,
  output logic [AW-1:0]       o_lu_wn,
  output logic [CW-1:0]       o_lu_cnt
);

  if (DIV_LAT <= DEPTH) begin : g_bad_div_lat
    $error("fpu_hazard_ctrl: DIV_LAT must be greater than DEPTH");
  end
  if (SQRT_LAT <= DEPTH) begin : g_bad_sqrt_lat
    $error("fpu_hazard_ctrl: SQRT_LAT must be greater than DEPTH");
  end
  if ((64'd1 << CW) <= 64'(DIV_LAT) || (64'd1 << CW) <= 64'(SQRT_LAT)) begin : g_bad_cw
    $error("fpu_hazard_ctrl: CW too narrow for iterative-unit latency");
  end

  logic [DEPTH*AW-1:0] w_e_n;
  logic [DEPTH-1:0]    w_e_w;
  logic [CW-1:0]       r_lu_cnt;
  logic [AW-1:0]       r_lu_wn;
  logic                w_lu_busy;
  logic                w_lu_issue;
  logic                w_struct;
  logic                w_stall;
  op_hz_t              w_hz_a;
  op_hz_t              w_hz_b;

  assign w_lu_busy = (r_lu_cnt != '0);

  // Youngest producer wins: EX load, MEM load, e1..e(DEPTH-1), eDEPTH, iterative unit.
  function automatic op_hz_t resolve(input logic [AW-1:0] x, input logic use_x);
    op_hz_t h;
    logic   mid;
    h.stall = 1'b0;
    h.fwd   = FWD_RF;
    mid     = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++)
      mid = mid | (w_e_w[k] && (w_e_n[k*AW +: AW] == x));
    if (use_x) begin
      if (i_ex_lwc1 && (i_ex_ld_rt == x)) begin
        h.stall = 1'b1;
      end else if (i_mem_lwc1 && (i_mem_ld_rt == x)) begin
`ifdef FPU_LOAD_FWD_EN
        h.fwd = FWD_LD;
`else
        h.stall = 1'b1;
`endif
      end else if (mid) begin
        h.stall = 1'b1;
      end else if (w_e_w[DEPTH-1] && (w_e_n[(DEPTH-1)*AW +: AW] == x)) begin
        h.fwd = FWD_FP;
      end else if (w_lu_busy && (r_lu_wn == x)) begin
        h.stall = 1'b1;
      end
    end
    return h;
  endfunction

  always_comb begin
    w_hz_a   = resolve(i_id_fs, i_id_use_fs);
    w_hz_b   = resolve(i_id_ft, i_id_use_ft);
    w_struct = (i_id_fop | i_id_ldiv | i_id_lsqrt) & w_lu_busy;
    w_stall  = ~i_clr & (w_hz_a.stall | w_hz_b.stall | w_struct);
  end

  assign w_lu_issue = (i_id_ldiv | i_id_lsqrt) & ~w_stall;

  fpu_stage_track #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_track (
    .i_clk (i_clk),
    .i_clr (i_clr),
    .i_fd  (i_id_fd),
    .i_we  (i_id_wf & i_id_fop & ~w_stall),
    .o_e_n (w_e_n),
    .o_e_w (w_e_w)
  );

  // Iterative unit can only be issued while idle, so a load never overlaps a countdown.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_lu_cnt <= '0;
      r_lu_wn  <= '0;
    end else if (w_lu_issue) begin
      r_lu_cnt <= i_id_ldiv ? CW'(DIV_LAT) : CW'(SQRT_LAT);
      r_lu_wn  <= i_id_fd;
    end else if (w_lu_busy) begin
      r_lu_cnt <= r_lu_cnt - 1'b1;
    end
  end

  assign o_stall   = w_stall;
  assign o_fwd_a   = i_clr ? FWD_RF : w_hz_a.fwd;
  assign o_fwd_b   = i_clr ? FWD_RF : w_hz_b.fwd;
  assign o_e_n     = w_e_n;
  assign o_e_w     = w_e_w;
  assign o_lu_busy = w_lu_busy;
  assign o_lu_done = (r_lu_cnt == CW'(1));
  assign o_lu_wn   = r_lu_wn;
  assign o_lu_cnt  = r_lu_cnt;

endmodule

// File: tb/tb_fpu_hazard_ctrl.sv
// Directed bench for fpu_hazard_ctrl: a DEPTH=3 and a DEPTH=5 instance share
// one stimulus stream; expectations follow FPU_LOAD_FWD_EN when it is defined.
module tb_fpu_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] id_fs, id_ft, id_fd, ex_ld_rt, mem_ld_rt;
  logic       id_use_fs, id_use_ft, id_fop, id_ldiv, id_lsqrt, id_wf;
  logic       ex_lwc1, mem_lwc1;

  logic        stall, lu_busy, lu_done;
  logic [1:0]  fwd_a, fwd_b;
  logic [14:0] e_n;
  logic [2:0]  e_w;
  logic [4:0]  lu_wn, lu_cnt;

  logic        stall5, lu_busy5, lu_done5;
  logic [1:0]  fwd_a5, fwd_b5;
  logic [24:0] e_n5;
  logic [4:0]  e_w5;
  logic [4:0]  lu_wn5, lu_cnt5;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fpu_hazard_ctrl #(.DEPTH(3)) u_dut (
    .i_clk(clk), .i_clr(clr),
    .i_id_fs(id_fs), .i_id_ft(id_ft), .i_id_use_fs(id_use_fs), .i_id_use_ft(id_use_ft),
    .i_id_fop(id_fop), .i_id_ldiv(id_ldiv), .i_id_lsqrt(id_lsqrt), .i_id_wf(id_wf),
    .i_id_fd(id_fd), .i_ex_lwc1(ex_lwc1), .i_ex_ld_rt(ex_ld_rt),
    .i_mem_lwc1(mem_lwc1), .i_mem_ld_rt(mem_ld_rt),
    .o_stall(stall), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_e_n(e_n), .o_e_w(e_w),
    .o_lu_busy(lu_busy), .o_lu_done(lu_done), .o_lu_wn(lu_wn), .o_lu_cnt(lu_cnt)
  );

  fpu_hazard_ctrl #(.DEPTH(5)) u_dut5 (
    .i_clk(clk), .i_clr(clr),
    .i_id_fs(id_fs), .i_id_ft(id_ft), .i_id_use_fs(id_use_fs), .i_id_use_ft(id_use_ft),
    .i_id_fop(id_fop), .i_id_ldiv(id_ldiv), .i_id_lsqrt(id_lsqrt), .i_id_wf(id_wf),
    .i_id_fd(id_fd), .i_ex_lwc1(ex_lwc1), .i_ex_ld_rt(ex_ld_rt),
    .i_mem_lwc1(mem_lwc1), .i_mem_ld_rt(mem_ld_rt),
    .o_stall(stall5), .o_fwd_a(fwd_a5), .o_fwd_b(fwd_b5), .o_e_n(e_n5), .o_e_w(e_w5),
    .o_lu_busy(lu_busy5), .o_lu_done(lu_done5), .o_lu_wn(lu_wn5), .o_lu_cnt(lu_cnt5)
  );

  task automatic clear_inputs();
    id_fs = '0; id_ft = '0; id_fd = '0; ex_ld_rt = '0; mem_ld_rt = '0;
    id_use_fs = 1'b0; id_use_ft = 1'b0; id_fop = 1'b0; id_ldiv = 1'b0;
    id_lsqrt = 1'b0; id_wf = 1'b0; ex_lwc1 = 1'b0; mem_lwc1 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    clr = 1'b1;
    tick();
    use_hazard_during_reset();
    #1;
    n_checks++;
    if ({e_n, e_w, lu_cnt, lu_wn, lu_busy, lu_done} !== '0)
      $display("[TB] FAIL reset_state: got %0h want 0", {e_n, e_w, lu_cnt, lu_wn, lu_busy, lu_done});
    else n_pass++;
    n_checks++;
    if ({stall, fwd_a, fwd_b} !== 5'd0)
      $display("[TB] FAIL reset_comb: got %0h want 0", {stall, fwd_a, fwd_b});
    else n_pass++;
    clear_inputs();
    clr = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("[TB] FAIL reset_release_stall: got %0b want 0", stall);
    else n_pass++;
  endtask

  task automatic use_hazard_during_reset();
    ex_lwc1 = 1'b1; ex_ld_rt = 5'd2; mem_lwc1 = 1'b1; mem_ld_rt = 5'd1;
    id_use_fs = 1'b1; id_fs = 5'd1; id_use_ft = 1'b1; id_ft = 5'd2; id_fop = 1'b1;
  endtask

  task automatic test_fp_raw();
    tick(); clear_inputs();
    id_fop = 1'b1; id_wf = 1'b1; id_fd = 5'd3;
    id_use_fs = 1'b1; id_fs = 5'd1; id_use_ft = 1'b1; id_ft = 5'd2;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("[TB] FAIL raw_issue_stall: got %0b want 0", stall);
    else n_pass++;
    tick();
    id_fs = 5'd3; id_fd = 5'd6;
    #1;
    n_checks++;
    if ({stall, e_w, e_n[4:0]} !== {1'b1, 3'b001, 5'd3})
      $display("[TB] FAIL raw_c1: got stall=%0b e_w=%b e1=%0d want 1 001 3", stall, e_w, e_n[4:0]);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({stall, e_w} !== {1'b1, 3'b010})
      $display("[TB] FAIL raw_c2: got stall=%0b e_w=%b want 1 010", stall, e_w);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({stall, fwd_a, fwd_b, e_w, e_n[14:10]} !== {1'b0, 2'd2, 2'd0, 3'b100, 5'd3})
      $display("[TB] FAIL raw_c3: got stall=%0b fwd_a=%0d fwd_b=%0d e_w=%b e3=%0d want 0 2 0 100 3",
               stall, fwd_a, fwd_b, e_w, e_n[14:10]);
    else n_pass++;
    tick(); clear_inputs(); #1;
    n_checks++;
    if ({e_w, e_n[4:0]} !== {3'b001, 5'd6})
      $display("[TB] FAIL raw_mul_in_e1: got e_w=%b e1=%0d want 001 6", e_w, e_n[4:0]);
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_load_use();
    tick(); clear_inputs();
    ex_lwc1 = 1'b1; ex_ld_rt = 5'd5;
    id_fop = 1'b1; id_wf = 1'b1; id_fd = 5'd7;
    id_use_fs = 1'b1; id_fs = 5'd1; id_use_ft = 1'b1; id_ft = 5'd5;
    #1;
    n_checks++;
    if (stall !== 1'b1) $display("[TB] FAIL ldu_c1_stall: got %0b want 1", stall);
    else n_pass++;
    tick();
    ex_lwc1 = 1'b0; mem_lwc1 = 1'b1; mem_ld_rt = 5'd5;
    #1;
`ifdef FPU_LOAD_FWD_EN
    n_checks++;
    if ({stall, fwd_a, fwd_b} !== {1'b0, 2'd0, 2'd1})
      $display("[TB] FAIL ldu_c2_fwd: got stall=%0b fwd_a=%0d fwd_b=%0d want 0 0 1", stall, fwd_a, fwd_b);
    else n_pass++;
`else
    n_checks++;
    if ({stall, fwd_b} !== {1'b1, 2'd0})
      $display("[TB] FAIL ldu_c2_stall: got stall=%0b fwd_b=%0d want 1 0", stall, fwd_b);
    else n_pass++;
    tick();
    mem_lwc1 = 1'b0;
    #1;
    n_checks++;
    if ({stall, fwd_b} !== {1'b0, 2'd0})
      $display("[TB] FAIL ldu_c3_rf: got stall=%0b fwd_b=%0d want 0 0", stall, fwd_b);
    else n_pass++;
`endif
    tick(); clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_ld_priority();
    tick(); clear_inputs();
    id_fop = 1'b1; id_wf = 1'b1; id_fd = 5'd4;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("[TB] FAIL prio_issue_stall: got %0b want 0", stall);
    else n_pass++;
    tick(); clear_inputs();
    tick(); tick();
    id_fop = 1'b1; id_use_fs = 1'b1; id_fs = 5'd4;
    #1;
    n_checks++;
    if ({stall, fwd_a} !== {1'b0, 2'd2})
      $display("[TB] FAIL prio_edepth_only: got stall=%0b fwd_a=%0d want 0 2", stall, fwd_a);
    else n_pass++;
    mem_lwc1 = 1'b1; mem_ld_rt = 5'd4;
    #1;
`ifdef FPU_LOAD_FWD_EN
    n_checks++;
    if ({stall, fwd_a} !== {1'b0, 2'd1})
      $display("[TB] FAIL prio_load_wins: got stall=%0b fwd_a=%0d want 0 1", stall, fwd_a);
    else n_pass++;
`else
    n_checks++;
    if ({stall, fwd_a} !== {1'b1, 2'd0})
      $display("[TB] FAIL prio_load_wins: got stall=%0b fwd_a=%0d want 1 0", stall, fwd_a);
    else n_pass++;
`endif
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reg0();
    tick(); clear_inputs();
    id_fop = 1'b1; id_wf = 1'b1; id_fd = 5'd0;
    tick(); clear_inputs();
    id_fop = 1'b1; id_use_ft = 1'b1; id_ft = 5'd0;
    #1;
    n_checks++;
    if ({stall, fwd_b} !== {1'b1, 2'd0})
      $display("[TB] FAIL reg0_stall: got stall=%0b fwd_b=%0d want 1 0", stall, fwd_b);
    else n_pass++;
    id_use_ft = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("[TB] FAIL reg0_unused_operand: got %0b want 0", stall);
    else n_pass++;
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_div();
    tick(); clear_inputs();
    id_ldiv = 1'b1; id_wf = 1'b1; id_fd = 5'd8;
    #1;
    n_checks++;
    if ({stall, lu_busy} !== 2'b00)
      $display("[TB] FAIL div_issue: got stall=%0b busy=%0b want 0 0", stall, lu_busy);
    else n_pass++;
    tick(); clear_inputs();
    id_fop = 1'b1; id_wf = 1'b1; id_fd = 5'd9; id_use_fs = 1'b1; id_fs = 5'd8;
    for (int c = 16; c >= 1; c--) begin
      #1;
      n_checks++;
      if ({lu_cnt, lu_busy, lu_done, lu_wn, stall} !== {5'(c), 1'b1, (c == 1), 5'd8, 1'b1})
        $display("[TB] FAIL div_count_%0d: got cnt=%0d busy=%0b done=%0b wn=%0d stall=%0b want %0d 1 %0b 8 1",
                 c, lu_cnt, lu_busy, lu_done, lu_wn, stall, c, (c == 1));
      else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if ({lu_cnt, lu_busy, lu_done, stall} !== {5'd0, 1'b0, 1'b0, 1'b0})
      $display("[TB] FAIL div_release: got cnt=%0d busy=%0b done=%0b stall=%0b want 0 0 0 0",
               lu_cnt, lu_busy, lu_done, stall);
    else n_pass++;
    tick(); clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_sqrt();
    tick(); clear_inputs();
    id_lsqrt = 1'b1; id_wf = 1'b1; id_fd = 5'd12;
    tick(); clear_inputs();
    id_use_ft = 1'b1; id_ft = 5'd12;
    #1;
    n_checks++;
    if ({lu_cnt, lu_wn, stall} !== {5'd16, 5'd12, 1'b1})
      $display("[TB] FAIL sqrt_raw: got cnt=%0d wn=%0d stall=%0b want 16 12 1", lu_cnt, lu_wn, stall);
    else n_pass++;
    id_ft = 5'd13;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("[TB] FAIL sqrt_store_other: got %0b want 0", stall);
    else n_pass++;
    id_fop = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b1) $display("[TB] FAIL sqrt_structural: got %0b want 1", stall);
    else n_pass++;
    clear_inputs();
    repeat (16) tick();
    n_checks++;
    if ({lu_busy, lu_cnt} !== 6'd0)
      $display("[TB] FAIL sqrt_drain: got busy=%0b cnt=%0d want 0 0", lu_busy, lu_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    tick(); clear_inputs();
    id_ldiv = 1'b1; id_wf = 1'b1; id_fd = 5'd8;
    tick(); clear_inputs();
    repeat (9) tick();
    n_checks++;
    if (lu_cnt !== 5'd7) $display("[TB] FAIL middiv_cnt: got %0d want 7", lu_cnt);
    else n_pass++;
    clr = 1'b1;
    use_hazard_during_reset();
    #1;
    n_checks++;
    if ({e_n, e_w, lu_cnt, lu_wn, lu_busy, lu_done, stall, fwd_a, fwd_b} !== '0)
      $display("[TB] FAIL middiv_async_clear: got %0h want 0",
               {e_n, e_w, lu_cnt, lu_wn, lu_busy, lu_done, stall, fwd_a, fwd_b});
    else n_pass++;
    tick();
    n_checks++;
    if ({lu_cnt, lu_wn, lu_busy, lu_done, stall} !== '0)
      $display("[TB] FAIL middiv_edge_clear: got %0h want 0", {lu_cnt, lu_wn, lu_busy, lu_done, stall});
    else n_pass++;
    clear_inputs();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({lu_done, lu_cnt} !== 6'd0)
        $display("[TB] FAIL middiv_no_done_%0d: got done=%0b cnt=%0d want 0 0", i, lu_done, lu_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_depth5();
    clear_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    id_fop = 1'b1; id_wf = 1'b1; id_fd = 5'd3;
    #1;
    n_checks++;
    if (stall5 !== 1'b0) $display("[TB] FAIL d5_issue_stall: got %0b want 0", stall5);
    else n_pass++;
    tick(); clear_inputs();
    id_fop = 1'b1; id_use_fs = 1'b1; id_fs = 5'd3;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if ({stall5, e_w5} !== {1'b1, 5'b00001 << k})
        $display("[TB] FAIL d5_stage_e%0d: got stall=%0b e_w=%b want 1 %b", k + 1, stall5, e_w5, 5'b00001 << k);
      else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if ({stall5, fwd_a5, e_w5, e_n5[24:20]} !== {1'b0, 2'd2, 5'b10000, 5'd3})
      $display("[TB] FAIL d5_e5_fwd: got stall=%0b fwd_a=%0d e_w=%b e5=%0d want 0 2 10000 3",
               stall5, fwd_a5, e_w5, e_n5[24:20]);
    else n_pass++;
    tick(); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fp_raw();
    test_load_use();
    test_ld_priority();
    test_reg0();
    test_div();
    test_sqrt();
    test_reset_mid_div();
    test_depth5();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
